// File: rtl/iob_ram_sp_be.sv
// iob_ram_sp_be_ctrl: valid/ready request front-end for the single-port
// byte-enable RAM (read-first, 1-cycle read latency). Requests become RAM
// strobes combinationally. Read data comes back one cycle later and is
// captured into a 3-entry response buffer.
//
// Flow control is credit based. A read holds a credit from the moment it is
// accepted until its response is popped. With 3 credits, a buffer slot is
// always free when data returns. Because req_ready depends only on local
// registers, there is no combinational path from rsp_ready to req_ready.

module iob_ram_sp_be_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                busy,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_din,
  input  logic [DATA_W-1:0]   mem_dout
);

  localparam int STRB_W = DATA_W / 8;

  logic              init_done;
  logic              rd_pend;
  logic [1:0]        wr_ptr;
  logic [1:0]        rd_ptr;
  logic [1:0]        occ;
  logic [DATA_W-1:0] fifo_mem [0:2];

  logic              acc;
  logic              rd_acc;
  logic              push;
  logic              pop;
  logic [2:0]        credit_used;

  // The buffer has 3 slots, so a pointer wraps from 2 back to 0.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Credits in use: reads already buffered plus the one still coming back from the RAM.
  assign credit_used = {1'b0, occ} + {2'b00, rd_pend};
  assign req_ready   = init_done & (credit_used < 3'd3);

  assign acc    = req_valid & req_ready;
  assign rd_acc = acc & (req_wstrb == {STRB_W{1'b0}});
  assign push   = rd_pend;
  assign pop    = rsp_valid & rsp_ready;

  assign mem_en   = acc;
  assign mem_we   = acc ? req_wstrb : {STRB_W{1'b0}};
  assign mem_addr = req_addr;
  assign mem_din  = req_wdata;

  assign rsp_valid = (occ != 2'd0);
  assign rsp_rdata = fifo_mem[rd_ptr];
  assign busy      = rd_pend | (occ != 2'd0);

  // Hold off requests for the first edge after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) init_done <= 1'b0;
    else        init_done <= 1'b1;
  end

  // Mark that the RAM will present read data during the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_pend <= 1'b0;
    else        rd_pend <= rd_acc;
  end

  // Buffer pointers and occupancy. A push and a pop in the same cycle cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      occ    <= 2'd0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Capture the RAM's read data into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_dout;
  end

endmodule

// File: tb/tb_iob_ram_sp_be_ctrl.sv
// Self-checking bench for iob_ram_sp_be_ctrl. It includes a behavioural
// read-first byte-enable RAM. The reference model is a shadow memory plus a
// queue of outstanding reads. A monitor compares DUT outputs against the
// model and pops expected responses as the DUT delivers them.

module tb_iob_ram_sp_be_ctrl;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  typedef struct {
    logic [31:0] data;
    int          a;
  } exp_t;

  typedef struct {
    logic [31:0] data;
    int          a;
    int          p;
  } log_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        busy;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  logic [31:0] ram    [0:1023];
  logic [31:0] shadow [0:1023];

  exp_t exp_q[$];
  log_t pop_log[$];

  int cyc = 0;
  bit init_m = 0;
  bit last_acc = 0;
  int acc_edge = 0;
  int stall_cnt = 0;
  int pass_cnt = 0;
  int total_cnt = 0;

  iob_ram_sp_be_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural read-first single-port RAM with byte write enables.
  always @(posedge clk) begin
    if (mem_en) begin
      mem_dout <= ram[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr][b*8 +: 8] <= mem_din[b*8 +: 8];
    end
  end

  // Edge counter used to time-stamp accepts and pops.
  always @(posedge clk) cyc++;

  // Model of init and reset: reset discards every outstanding read.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_m = 0;
      exp_q.delete();
    end else begin
      init_m = 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h time=%0t", name, act, exp, $time);
    else
      pass_cnt++;
  endtask

  // Record requests that the coming edge will accept: apply writes to the shadow and queue read results.
  always @(negedge clk) begin
    last_acc = 0;
    if (rst_n && req_valid && !req_ready) stall_cnt++;
    if (rst_n && req_valid && req_ready) begin
      last_acc = 1;
      acc_edge = cyc + 1;
      if (req_wstrb != 4'b0000) begin
        for (int b = 0; b < 4; b++)
          if (req_wstrb[b]) shadow[req_addr][b*8 +: 8] = req_wdata[b*8 +: 8];
      end else begin
        exp_q.push_back('{data: shadow[req_addr], a: cyc + 1});
      end
    end
  end

  // Monitor: compare outputs with the credit/latency model and retire responses in order.
  always @(negedge clk) begin
    int outs;
    bit exp_ready;
    bit exp_valid;
    #1;
    if (!rst_n) begin
      checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd0);
      checkOutput("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      checkOutput("rst_busy", {31'b0, busy}, 32'd0);
      checkOutput("rst_mem_en", {31'b0, mem_en}, 32'd0);
      checkOutput("rst_mem_we", {28'b0, mem_we}, 32'd0);
    end else begin
      outs = 0;
      foreach (exp_q[i]) if (exp_q[i].a <= cyc) outs++;
      checkOutput("outstanding_le_3", (outs <= 3) ? 32'd1 : 32'd0, 32'd1);
      exp_ready = init_m && (outs < 3);
      exp_valid = (exp_q.size() > 0) && (exp_q[0].a + 1 <= cyc);
      checkOutput("req_ready", {31'b0, req_ready}, {31'b0, exp_ready});
      checkOutput("busy", {31'b0, busy}, (outs != 0) ? 32'd1 : 32'd0);
      checkOutput("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_valid});
      checkOutput("mem_en", {31'b0, mem_en}, {31'b0, req_valid && exp_ready});
      checkOutput("mem_we", {28'b0, mem_we}, (req_valid && exp_ready) ? {28'b0, req_wstrb} : 32'd0);
      if (req_valid && exp_ready) begin
        checkOutput("mem_addr", {22'b0, mem_addr}, {22'b0, req_addr});
        checkOutput("mem_din", mem_din, req_wdata);
      end
      if (rsp_valid && rsp_ready && exp_valid) begin
        checkOutput("rsp_rdata", rsp_rdata, exp_q[0].data);
        pop_log.push_back('{data: rsp_rdata, a: exp_q[0].a, p: cyc + 1});
        void'(exp_q.pop_front());
      end
    end
  end

  // Drive one cycle of request inputs, then wait until just after the next edge.
  task automatic applyStimulus(input bit v, input logic [9:0] a, input logic [31:0] d, input logic [3:0] s);
    req_valid = v;
    req_addr  = a;
    req_wdata = d;
    req_wstrb = s;
    @(posedge clk);
    #1;
  endtask

  // Hold a request until it is accepted, bounded.
  task automatic issue(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s);
    bit done;
    done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      applyStimulus(1'b1, a, d, s);
      done = last_acc;
    end
    if (!done) checkOutput("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 10'd0, 32'd0, 4'd0);
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    for (int k = 0; k < 50 && (exp_q.size() != 0 || busy); k++) idle(1);
    checkOutput("drain_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int nacc;
    for (int i = 0; i < 1024; i++) shadow[i] = 32'd0;
    rst_n = 1'b0;
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr = 10'd0;
    req_wdata = 32'd0;
    req_wstrb = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_valid = 1'b0;
    checkOutput("init_ready_low", {31'b0, req_ready}, 32'd0);
    idle(1);
    checkOutput("init_ready_high", {31'b0, req_ready}, 32'd1);

    $display("[TB] preload addr 0..31");
    for (int i = 0; i < 32; i++) issue(i[9:0], i, 4'hF);
    idle(2);

    $display("[TB] streaming reads");
    pop_log.delete();
    stall_cnt = 0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) issue(i[9:0], 32'd0, 4'd0);
    idle(4);
    drain();
    checkOutput("stream_stalls", stall_cnt, 32'd0);
    checkOutput("stream_count", pop_log.size(), 32'd16);
    if (pop_log.size() == 16) begin
      checkOutput("stream_first_latency", pop_log[0].p - pop_log[0].a, 32'd2);
      for (int i = 0; i < 16; i++) begin
        checkOutput("stream_data", pop_log[i].data, i);
        checkOutput("stream_edge", pop_log[i].p - pop_log[0].p, i);
      end
    end

    $display("[TB] backpressure");
    pop_log.delete();
    rsp_ready = 1'b0;
    nacc = 0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 10'(1 + nacc), 32'd0, 4'd0);
      if (last_acc) nacc++;
    end
    checkOutput("bp_accepted", nacc, 32'd3);
    checkOutput("bp_ready_low", {31'b0, req_ready}, 32'd0);
    rsp_ready = 1'b1;
    applyStimulus(1'b1, 10'd4, 32'd0, 4'd0);
    checkOutput("bp_no_acc_on_pop", {31'b0, last_acc}, 32'd0);
    rsp_ready = 1'b0;
    applyStimulus(1'b1, 10'd4, 32'd0, 4'd0);
    checkOutput("bp_4th_next_cycle", {31'b0, last_acc}, 32'd1);
    idle(2);
    drain();
    checkOutput("bp_count", pop_log.size(), 32'd4);
    if (pop_log.size() == 4)
      for (int i = 0; i < 4; i++) checkOutput("bp_order", pop_log[i].data, i + 1);

    $display("[TB] byte strobes");
    pop_log.delete();
    rsp_ready = 1'b1;
    issue(10'd5, 32'hAABBCCDD, 4'b1111);
    issue(10'd5, 32'h11223344, 4'b0101);
    issue(10'd5, 32'd0, 4'b0000);
    idle(3);
    drain();
    checkOutput("strb_count", pop_log.size(), 32'd1);
    if (pop_log.size() == 1) begin
      checkOutput("strb_data", pop_log[0].data, 32'hAA22CC44);
      checkOutput("strb_latency", pop_log[0].p - pop_log[0].a, 32'd2);
    end

    $display("[TB] read after write");
    pop_log.delete();
    issue(10'd7, 32'hDEADBEEF, 4'hF);
    issue(10'd7, 32'd0, 4'd0);
    idle(3);
    drain();
    checkOutput("raw_count", pop_log.size(), 32'd1);
    if (pop_log.size() == 1) checkOutput("raw_data", pop_log[0].data, 32'hDEADBEEF);

    $display("[TB] random traffic with mid-burst reset");
    for (int i = 0; i < 400; i++) begin
      bit wr;
      if (i == 200) begin
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
          rsp_ready = $urandom_range(0, 1);
          applyStimulus(1'b1, 10'($urandom % 32), $urandom, 4'd0);
        end
        req_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        checkOutput("rel_ready_low", {31'b0, req_ready}, 32'd0);
        checkOutput("rel_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        idle(1);
        checkOutput("rel_ready_high", {31'b0, req_ready}, 32'd1);
      end
      rsp_ready = ($urandom % 4) != 0;
      wr = $urandom_range(0, 1);
      applyStimulus(($urandom % 10) < 7, 10'($urandom % 32), $urandom,
                    wr ? 4'(($urandom % 15) + 1) : 4'd0);
    end
    idle(1);
    drain();

    $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/iob_ram_sp_be_ctrl.md
# iob_ram_sp_be_ctrl

Request/response front-end for the single-port byte-enable RAM (`iob_ram_sp_be`, read-first, 1-cycle read latency). It sits directly upstream of that RAM. It converts a valid/ready request stream into RAM `en`/`we`/`addr`/`din` strobes. It captures read data into a 3-entry response buffer, so the downstream consumer can apply backpressure without losing data and without a combinational `rsp_ready`→`req_ready` path.

## Interface
Parameters:
- `ADDR_W`, 10, word address width; must match the RAM.
- `DATA_W`, 32, data width; multiple of 8. The strobe width is `DATA_W/8`.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid & req_ready` at a rising edge.
- `req_addr`  in  ADDR_W  word address.
- `req_wdata`  in  DATA_W  write data.
- `req_wstrb`  in  DATA_W/8  byte strobes. Non-zero means write; all-zero means read.
- `rsp_valid`  out  1  read data available at the buffer head.
- `rsp_ready`  in  1  consumer takes the head entry when `rsp_valid & rsp_ready`.
- `rsp_rdata`  out  DATA_W  head-entry read data.
- `busy`  out  1  a read is in flight or the buffer is non-empty.
- `mem_en`  out  1  to RAM `en`.
- `mem_we`  out  DATA_W/8  to RAM `we`.
- `mem_addr`  out  ADDR_W  to RAM `addr`.
- `mem_din`  out  DATA_W  to RAM `din`.
- `mem_dout`  in  DATA_W  from RAM `dout`.

## Operation
- State:
  - `init_done` flop, cleared by reset and set on the first edge after release.
  - `rd_pend` flop: a read was issued last cycle.
  - Response FIFO: 3 entries × DATA_W, 2-bit read/write pointers wrapping 2→0, 2-bit `occ` (0..3).
- `req_ready = init_done & (occ + rd_pend < 3)`. It depends only on registers, never on `rsp_ready` or `req_valid`.
- Accept (`acc = req_valid & req_ready`):
  - `mem_en = acc`, `mem_addr = req_addr`, `mem_din = req_wdata`, `mem_we = acc ? req_wstrb : 0`. These outputs are combinational pass-through.
- Write accept: RAM updates the strobed bytes at that edge. No response is produced. The RAM's read-first `dout` is ignored.
- Read accept: `rd_pend` is set for the next cycle. In that cycle `mem_dout` is pushed into the FIFO at the edge.
- Pop: `rsp_valid & rsp_ready` advances the read pointer.
- Occupancy: push and pop in the same cycle leave `occ` unchanged.
- `rsp_valid = (occ != 0)`; `rsp_rdata = fifo[rd_ptr]`, read from registered storage.
- `busy = rd_pend | (occ != 0)`.
- Overflow is impossible by construction. A push never occurs when `occ == 3`, because the credit check includes `rd_pend`.
- Ordering: responses return strictly in read-accept order. A read issued the cycle after a write to the same address returns the new data.
- `rsp_rdata` when `rsp_valid` is 0 is don't-care. Verification must not check it.

## Timing
- Reset (async assert, any cycle):
  - `init_done=0`, `rd_pend=0`, `occ=0`, pointers 0.
  - Outputs: `req_ready=0`, `rsp_valid=0`, `busy=0`, `mem_en=0`, `mem_we=0`.
  - A read in flight is discarded, and buffered data is lost.
- After `rst_n` rises, `req_ready` is first 1 in the cycle following the first rising edge.
- Read latency: accept at edge N → `mem_en=1` in cycle N → data pushed at edge N+1 → `rsp_valid=1` from cycle N+2. Accept-to-response is 2 cycles.
- Throughput:
  - With `rsp_ready` held 1, one read per cycle is sustained indefinitely; steady state is `occ=1`, `rd_pend=1`.
  - Writes are one per cycle whenever `req_ready=1`.
- Backpressure: with `rsp_ready=0`, at most 3 reads are accepted. `req_ready` falls in the cycle after the 3rd read accept (`occ+rd_pend = 3`). Writes are also blocked while `req_ready=0`.
- After one pop from a full buffer, `req_ready` returns to 1 in the next cycle.

## Test plan
- Reset/init: assert `rst_n=0` mid-burst.
  - All outputs 0 while `rst_n=0`.
  - After release, `req_ready=0` for 1 cycle, then 1.
  - No stale `rsp_valid`.
- Byte strobes:
  - Write 0xAABBCCDD to addr 5 with `wstrb=1111`, then 0x11223344 with `wstrb=0101`, then read addr 5.
  - `rsp_rdata = 0xAA22CC44`, 2 cycles after the read accept.
- Streaming reads:
  - Preload addr 0..15 with value = addr, hold `req_valid=1` and `rsp_ready=1`, read 0..15.
  - 16 responses on 16 consecutive cycles, in order, first at accept+2, `req_ready` never drops.
- Backpressure:
  - With `rsp_ready=0`, issue reads to addr 1, 2, 3, 4.
  - Exactly 3 accepted; `req_ready=0` thereafter.
  - Raise `rsp_ready` for one cycle: data 1 popped, the 4th read accepted the next cycle, and the final order is 1, 2, 3, 4.
- Read-after-write: write 0xDEADBEEF to addr 7 at edge N, read addr 7 at edge N+1 → `rsp_rdata = 0xDEADBEEF`.
- Random: mixed reads and writes with random `req_valid` and `rsp_ready`, checked against a scoreboard model.
  - No lost, duplicated or reordered responses.
  - `occ ≤ 3`.
  - `busy` consistent with outstanding reads.
